// File: rtl/snake_pkg.sv
// Shared snake playfield definitions: grid geometry, random-source width,
// food placer state encoding and cell coordinate type.
package snake_pkg;

    localparam int unsigned GRID_W   = 40;
    localparam int unsigned GRID_H   = 30;
    localparam int unsigned X_BITS   = 6;
    localparam int unsigned Y_BITS   = 5;
    localparam int unsigned RND_BITS = 15;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_SAMPLE = 3'd2,
        S_QUERY  = 3'd3,
        S_SCAN   = 3'd4,
        S_DONE   = 3'd5,
        S_FAIL   = 3'd6
    } state_t;

    typedef struct packed {
        logic [Y_BITS-1:0] y;
        logic [X_BITS-1:0] x;
    } coord_t;

endpackage

// File: rtl/grid_scan_ctr.sv
// Raster x/y walker over the playfield. Loads a start cell, steps x then y
// with wrap on both axes, and flags when the next step lands on the start.
module grid_scan_ctr
    import snake_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [X_BITS-1:0] i_start_x,
    input  logic [Y_BITS-1:0] i_start_y,
    input  logic              i_step,
    output logic [X_BITS-1:0] o_x,
    output logic [Y_BITS-1:0] o_y,
    output logic              o_last_c
);

    logic [X_BITS-1:0] r_x;
    logic [Y_BITS-1:0] r_y;
    logic [X_BITS-1:0] r_start_x;
    logic [Y_BITS-1:0] r_start_y;
    logic [X_BITS-1:0] w_next_x;
    logic [Y_BITS-1:0] w_next_y;

    // Next raster position: x wraps at the right edge and carries into y.
    always_comb begin
        w_next_x = r_x + X_BITS'(1);
        w_next_y = r_y;
        if (r_x == X_BITS'(GRID_W - 1)) begin
            w_next_x = '0;
            w_next_y = (r_y == Y_BITS'(GRID_H - 1)) ? '0 : r_y + Y_BITS'(1);
        end
    end

    assign o_last_c = (w_next_x == r_start_x) && (w_next_y == r_start_y);
    assign o_x      = r_x;
    assign o_y      = r_y;

    // Position and start-cell registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_start_x <= '0;
            r_start_y <= '0;
        end else if (i_load) begin
            r_x       <= i_start_x;
            r_y       <= i_start_y;
            r_start_x <= i_start_x;
            r_start_y <= i_start_y;
        end else if (i_step) begin
            r_x       <= w_next_x;
            r_y       <= w_next_y;
        end
    end

endmodule

// File: rtl/food_placer.sv
// Food placer: draws candidate cells from the LFSR after a settle delay,
// range-checks them, asks the occupancy logic, and retries up to MAX_TRIES.
// Optional macro FOOD_SCAN_FALLBACK_EN adds a raster scan of the whole grid
// after the random draws are exhausted; without it exhaustion fails directly.
module food_placer
    import snake_pkg::*;
#(
    parameter int unsigned SETTLE    = 15,
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RND_BITS-1:0] rnd,
    input  logic                spawn_req,
    output logic                spawn_busy,
    output logic                occ_query,
    output logic [X_BITS-1:0]   occ_x,
    output logic [Y_BITS-1:0]   occ_y,
    input  logic                occ_valid,
    input  logic                occ_hit,
    output logic [X_BITS-1:0]   food_x,
    output logic [Y_BITS-1:0]   food_y,
    output logic                food_valid,
    output logic                spawn_fail
);

    localparam int unsigned        SETTLE_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned        TRY_W       = $clog2(MAX_TRIES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);
    localparam logic [TRY_W-1:0]    TRY_MAX     = TRY_W'(MAX_TRIES);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SETTLE_W-1:0] r_settle;
    logic [SETTLE_W-1:0] w_settle_nxt;
    logic [TRY_W-1:0]    r_tries;
    logic [TRY_W-1:0]    w_tries_nxt;
    logic [TRY_W-1:0]    w_tries_inc;
    coord_t              r_cand;
    coord_t              w_cand_nxt;
    coord_t              w_rnd_cand;
    coord_t              w_done_cand;
    coord_t              r_food;
    coord_t              w_food_nxt;
    logic                w_in_range;
    logic                w_reject;
    logic                w_exhausted;
    logic                r_busy;
    logic                r_query;
    logic                r_food_valid;
    logic                r_fail;
    logic                w_busy_nxt;
    logic                w_query_nxt;
    logic                w_food_valid_nxt;
    logic                w_fail_nxt;
    logic                w_unused_rnd;

    // Candidate straight from the random bits; out-of-range values are rejected, never folded.
    assign w_rnd_cand.x = rnd[X_BITS-1:0];
    assign w_rnd_cand.y = rnd[X_BITS+Y_BITS-1:X_BITS];
    assign w_in_range   = (w_rnd_cand.x < X_BITS'(GRID_W)) && (w_rnd_cand.y < Y_BITS'(GRID_H));
    assign w_unused_rnd = ^rnd[RND_BITS-1:X_BITS+Y_BITS];

    assign w_tries_inc = (r_tries == TRY_MAX) ? r_tries : r_tries + TRY_W'(1);
    assign w_exhausted = (w_tries_inc >= TRY_MAX);

`ifdef FOOD_SCAN_FALLBACK_EN
    logic [X_BITS-1:0] w_scan_x;
    logic [Y_BITS-1:0] w_scan_y;
    coord_t            w_scan_pos;
    coord_t            w_scan_start;
    logic              w_scan_load;
    logic              w_scan_step;
    logic              w_scan_last_c;

    // Scan starts at the last in-range draw, or the origin after a range reject.
    assign w_scan_start = (r_state == S_QUERY) ? r_cand : '0;
    assign w_scan_load  = w_reject && w_exhausted;
    assign w_scan_step  = (r_state == S_SCAN) && occ_valid && occ_hit;
    assign w_scan_pos   = {w_scan_y, w_scan_x};

    grid_scan_ctr u_scan (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_scan_load),
        .i_start_x (w_scan_start.x),
        .i_start_y (w_scan_start.y),
        .i_step    (w_scan_step),
        .o_x       (w_scan_x),
        .o_y       (w_scan_y),
        .o_last_c  (w_scan_last_c)
    );

    assign w_done_cand = (r_state == S_SCAN) ? w_scan_pos : r_cand;
    assign occ_x       = (r_state == S_SCAN) ? w_scan_x : r_cand.x;
    assign occ_y       = (r_state == S_SCAN) ? w_scan_y : r_cand.y;
`else
    assign w_done_cand = r_cand;
    assign occ_x       = r_cand.x;
    assign occ_y       = r_cand.y;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a reject either retries or takes the exhausted path.
    always_comb begin
        w_state_nxt = r_state;
        w_reject    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (spawn_req) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_settle == '0) w_state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (w_in_range) w_state_nxt = S_QUERY;
                else            w_reject    = 1'b1;
            end
            S_QUERY: begin
                if (occ_valid) begin
                    if (occ_hit) w_reject    = 1'b1;
                    else         w_state_nxt = S_DONE;
                end
            end
`ifdef FOOD_SCAN_FALLBACK_EN
            S_SCAN: begin
                if (occ_valid) begin
                    if (!occ_hit)          w_state_nxt = S_DONE;
                    else if (w_scan_last_c) w_state_nxt = S_FAIL;
                end
            end
`endif
            S_DONE:  w_state_nxt = S_IDLE;
            S_FAIL:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_reject) begin
            if (!w_exhausted) begin
                w_state_nxt = S_WAIT;
            end else begin
`ifdef FOOD_SCAN_FALLBACK_EN
                w_state_nxt = S_SCAN;
`else
                w_state_nxt = S_FAIL;
`endif
            end
        end
    end

    // Output and datapath next values, derived from the upcoming state.
    always_comb begin
        w_settle_nxt     = r_settle;
        w_tries_nxt      = r_tries;
        w_cand_nxt       = r_cand;
        w_food_nxt       = r_food;
        if ((r_state == S_IDLE) && spawn_req) begin
            w_settle_nxt = SETTLE_LOAD;
            w_tries_nxt  = '0;
        end
        if ((r_state == S_WAIT) && (r_settle != '0)) begin
            w_settle_nxt = r_settle - SETTLE_W'(1);
        end
        if (r_state == S_SAMPLE) begin
            w_cand_nxt = w_rnd_cand;
        end
        if (w_reject) begin
            w_tries_nxt  = w_tries_inc;
            w_settle_nxt = SETTLE_LOAD;
        end
        if (w_state_nxt == S_DONE) begin
            w_food_nxt = w_done_cand;
        end
        w_busy_nxt       = (w_state_nxt != S_IDLE);
        w_query_nxt      = (w_state_nxt == S_QUERY) || (w_state_nxt == S_SCAN);
        w_food_valid_nxt = (w_state_nxt == S_DONE);
        w_fail_nxt       = (w_state_nxt == S_FAIL);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_settle     <= '0;
            r_tries      <= '0;
            r_cand       <= '0;
            r_food       <= '0;
            r_busy       <= 1'b0;
            r_query      <= 1'b0;
            r_food_valid <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_settle     <= w_settle_nxt;
            r_tries      <= w_tries_nxt;
            r_cand       <= w_cand_nxt;
            r_food       <= w_food_nxt;
            r_busy       <= w_busy_nxt;
            r_query      <= w_query_nxt;
            r_food_valid <= w_food_valid_nxt;
            r_fail       <= w_fail_nxt;
        end
    end

    assign spawn_busy = r_busy;
    assign occ_query  = r_query;
    assign food_x     = r_food.x;
    assign food_y     = r_food.y;
    assign food_valid = r_food_valid;
    assign spawn_fail = r_fail;

endmodule

// File: tb/tb_food_placer.sv
// Randomized bench for food_placer against a timeline model of the placement
// rules. Honors FOOD_SCAN_FALLBACK_EN the same way the design does.
`timescale 1ns/1ps
module tb_food_placer;
    import snake_pkg::*;

    localparam int SETTLE    = 15;
    localparam int MAX_TRIES = 8;
    localparam int GW        = GRID_W;
    localparam int GH        = GRID_H;
    localparam int NCELL     = GW * GH;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] rnd;
    logic        spawn_req;
    logic        spawn_busy;
    logic        occ_query;
    logic [5:0]  occ_x;
    logic [4:0]  occ_y;
    logic        occ_valid;
    logic        occ_hit;
    logic [5:0]  food_x;
    logic [4:0]  food_y;
    logic        food_valid;
    logic        spawn_fail;

    int n_checks = 0;
    int n_errors = 0;

    bit          occ_map [0:NCELL-1];
    logic [14:0] draws [$];
    logic [14:0] rnd_at [int];
    int          q_x [int];
    int          q_y [int];
    int          v_hit [int];
    int          exp_r;
    bit          exp_ok;
    int          exp_fx, exp_fy;
    int          cur_fx, cur_fy;

    food_placer #(.SETTLE(SETTLE), .MAX_TRIES(MAX_TRIES)) dut (
        .clk        (clk),
        .rst        (rst),
        .rnd        (rnd),
        .spawn_req  (spawn_req),
        .spawn_busy (spawn_busy),
        .occ_query  (occ_query),
        .occ_x      (occ_x),
        .occ_y      (occ_y),
        .occ_valid  (occ_valid),
        .occ_hit    (occ_hit),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .spawn_fail (spawn_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] enc(input int x, input int y);
        int hi;
        hi = int'($urandom_range(0, 15));
        return 15'((hi << 11) | (y << 6) | x);
    endfunction

    task automatic set_map(input int pct);
        for (int i = 0; i < NCELL; i++) occ_map[i] = (int'($urandom_range(0, 99)) < pct);
    endtask

    // Timeline of one spawn; cycle 0 is the first cycle after spawn_req is taken.
    task automatic build_model(input int d);
        int t, s, dec, tries, di, cx, cy, lx, ly;
        bit lin, fin;
        logic [14:0] v;
        t = 0; tries = 0; di = 0; lin = 0; fin = 0; lx = 0; ly = 0; dec = 0;
        rnd_at.delete(); q_x.delete(); q_y.delete(); v_hit.delete();
        while (!fin) begin
            s = t + SETTLE;
            if (di < draws.size()) v = draws[di];
            else                   v = 15'($urandom);
            di++;
            rnd_at[s] = v;
            cx = int'(v) % 64;
            cy = (int'(v) / 64) % 32;
            if (cx >= GW || cy >= GH) begin
                tries++; lin = 0; dec = s;
            end else begin
                lin = 1; lx = cx; ly = cy;
                for (int k = 0; k <= d; k++) begin q_x[s+1+k] = cx; q_y[s+1+k] = cy; end
                v_hit[s+1+d] = int'(occ_map[cx + cy*GW]);
                if (!occ_map[cx + cy*GW]) begin
                    exp_r = s + 2 + d; exp_ok = 1; exp_fx = cx; exp_fy = cy; fin = 1;
                end else begin
                    tries++; dec = s + 1 + d;
                end
            end
            if (!fin) begin
                if (tries < MAX_TRIES) begin
                    t = dec + 1;
                end else begin
                    fin = 1;
`ifdef FOOD_SCAN_FALLBACK_EN
                    begin
                        int px, py, sx, sy, c;
                        bit sdone;
                        px = lin ? lx : 0; py = lin ? ly : 0;
                        sx = px; sy = py; c = dec + 1; sdone = 0;
                        while (!sdone) begin
                            for (int k = 0; k <= d; k++) begin q_x[c+k] = px; q_y[c+k] = py; end
                            v_hit[c+d] = int'(occ_map[px + py*GW]);
                            if (!occ_map[px + py*GW]) begin
                                exp_r = c + d + 1; exp_ok = 1; exp_fx = px; exp_fy = py; sdone = 1;
                            end else begin
                                px++;
                                if (px == GW) begin px = 0; py = (py + 1) % GH; end
                                c += d + 1;
                                if (px == sx && py == sy) begin exp_r = c; exp_ok = 0; sdone = 1; end
                            end
                        end
                    end
`else
                    exp_r = dec + 1; exp_ok = 0;
`endif
                end
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  int'(spawn_busy), 0);
        check({tag, "_query"}, int'(occ_query),  0);
        check({tag, "_occx"},  int'(occ_x),      0);
        check({tag, "_occy"},  int'(occ_y),      0);
        check({tag, "_foodx"}, int'(food_x),     0);
        check({tag, "_foody"}, int'(food_y),     0);
        check({tag, "_valid"}, int'(food_valid), 0);
        check({tag, "_fail"},  int'(spawn_fail), 0);
    endtask

    // Runs one spawn cycle by cycle; abort_at >= 0 pulls reset at that cycle.
    task automatic run_spawn(input int d, input int abort_at);
        bit exp_q;
        build_model(d);
        @(negedge clk);
        spawn_req = 1'b1;
        rnd       = 15'($urandom);
        occ_valid = 1'($urandom);
        occ_hit   = 1'($urandom);
        for (int c = 0; c <= exp_r + 1; c++) begin
            @(negedge clk);
            exp_q = q_x.exists(c);
            if (c == abort_at) begin
                check("pre_rst_query", int'(occ_query), exp_q ? 1 : 0);
                rst = 1'b0;
                spawn_req = 1'b1;
                #1;
                check_zero("rst");
                cur_fx = 0; cur_fy = 0;
                @(negedge clk);
                rst = 1'b1;
                spawn_req = 1'b0;
                occ_valid = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    check("post_rst_busy", int'(spawn_busy), 0);
                end
                return;
            end
            check("busy",  int'(spawn_busy), (c <= exp_r) ? 1 : 0);
            check("valid", int'(food_valid), (c == exp_r && exp_ok) ? 1 : 0);
            check("fail",  int'(spawn_fail), (c == exp_r && !exp_ok) ? 1 : 0);
            check("query", int'(occ_query),  exp_q ? 1 : 0);
            if (exp_q) begin
                check("occ_x", int'(occ_x), q_x[c]);
                check("occ_y", int'(occ_y), q_y[c]);
            end
            if (c == exp_r && exp_ok) begin cur_fx = exp_fx; cur_fy = exp_fy; end
            check("food_x", int'(food_x), cur_fx);
            check("food_y", int'(food_y), cur_fy);
            spawn_req = (c <= exp_r) ? 1'($urandom) : 1'b0;
            rnd       = rnd_at.exists(c) ? rnd_at[c] : 15'($urandom);
            if (v_hit.exists(c)) begin
                occ_valid = 1'b1;
                occ_hit   = 1'(v_hit[c]);
            end else if (exp_q) begin
                occ_valid = 1'b0;
                occ_hit   = 1'($urandom);
            end else begin
                occ_valid = 1'($urandom);
                occ_hit   = 1'($urandom);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired n_checks %0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int pcts [4];
        pcts[0] = 0; pcts[1] = 40; pcts[2] = 80; pcts[3] = 100;
        rst = 1'b0; spawn_req = 1'b0; rnd = '0; occ_valid = 1'b0; occ_hit = 1'b0;
        cur_fx = 0; cur_fy = 0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        // Best-case placement of (5,10).
        set_map(0);
        draws.delete(); draws.push_back(15'h0285);
        run_spawn(0, -1);

        // Three x range rejects, then (12,3).
        draws.delete();
        for (int i = 0; i < 3; i++) draws.push_back(enc(45, int'($urandom_range(0, 31))));
        draws.push_back(enc(12, 3));
        run_spawn(int'($urandom_range(0, 2)), -1);

        // Two occupied hits with slow answers, third candidate free.
        set_map(0);
        occ_map[7 + 2*GW] = 1'b1;
        occ_map[30 + 20*GW] = 1'b1;
        draws.delete();
        draws.push_back(enc(7, 2)); draws.push_back(enc(30, 20)); draws.push_back(enc(1, 1));
        run_spawn(4, -1);

        // Fully occupied board.
        set_map(100);
        draws.delete();
        run_spawn(0, -1);

        // Eight hits ending at (39,4); only (2,5) is free.
        set_map(100);
        occ_map[2 + 5*GW] = 1'b0;
        draws.delete();
        for (int i = 0; i < 7; i++)
            draws.push_back(enc(int'($urandom_range(10, 38)), int'($urandom_range(0, 29))));
        draws.push_back(enc(39, 4));
        run_spawn(1, -1);

        // Reset in the middle of a slow query, then a fresh spawn.
        set_map(0);
        draws.delete(); draws.push_back(enc(9, 9));
        run_spawn(10, SETTLE + 3);
        draws.delete(); draws.push_back(enc(20, 15));
        run_spawn(0, -1);

        // Random boards, draws and answer delays.
        for (int n = 0; n < 12; n++) begin
            set_map(pcts[$urandom_range(0, 3)]);
            draws.delete();
            run_spawn(int'($urandom_range(0, 2)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
